alu_issue: RTL and testbench
============================

# alu_issue

Two-stage issue/writeback controller that drives the combinational `Alu` (`alith`, `source1`, `source2` in; `alu_out` back) and owns a 4-entry × 16-bit register file. It accepts decoded operations over a valid/ready handshake, reads operands, presents them to the ALU for one cycle, and writes the result back into the register file. It sits between the decoder and the `Alu` instance in the processor datapath.

## Interface
- `DATA_W`, 16, operand/result width; must match `Alu`.
- `NREG`, 4, register count; register index width is `$clog2(NREG)`.
- Clock and reset: one clock; reset is asynchronous and active-low (`clk`, `rst_n`).
- `clk` in 1 — rising-edge clock.
- `rst_n` in 1 — asynchronous active-low reset.
- `in_valid` in 1 — decoded op offered.
- `in_ready` out 1 — op accepted on an edge where `in_valid && in_ready`.
- `in_op` in 3 — operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 LDI, 101–111 illegal.
- `in_rd`, `in_rs1`, `in_rs2` in 2 — destination and source register indices.
- `in_imm` in `DATA_W` — immediate value, used only by LDI.
- `alith` out 3 — ALU op select, registered.
- `source1`, `source2` out `DATA_W` — ALU operands, registered.
- `alu_out` in `DATA_W` — combinational ALU result.
- `wb_valid` out 1 — one-cycle pulse when a register is written.
- `wb_rd` out 2 — register written.
- `wb_data` out `DATA_W` — value written.
- `err` out 1 — sticky flag, set when an illegal op is accepted.
- `dbg_addr` in 2 — debug read index.
- `dbg_data` out `DATA_W` — combinational read of `RF[dbg_addr]`.

## Operation
- **E stage register:** holds `e_valid`, `e_op`, `e_rd`, `e_opa`, `e_opb`, `e_imm`. It is loaded on every accept and cleared when there is no accept.
- **ALU drive:** `alith = e_op`, `source1 = e_opa`, `source2 = e_opb`. These come directly from the E register. When `e_valid` is 0 they hold their last values; on reset they are 0.
- **Result of the E instruction:**
  - Ops 000–011: `alu_out`.
  - LDI: `e_imm`. LDI does not use the ALU result.
  - Illegal ops: no result and no writeback.
- **Writeback:** at the edge that ends E, `RF[e_rd] <= result`. In the same edge, `wb_valid <= 1`, `wb_rd <= e_rd`, `wb_data <= result`. Otherwise `wb_valid <= 0`.
- **Operand read:** operands are read from the RF when the op is accepted.
- **RAW hazard:** an incoming `rs1`/`rs2` equals `e_rd` while `e_valid` is set and the E op writes a register. Forwarding behaviour is defined under Configuration.
- **Arithmetic:** ADD and SUB are modulo 2^`DATA_W`, with no carry or flag out. Register 0 is an ordinary register, not hardwired to zero.
- **Reset:** all RF entries, the E register, `alith`, `source1`, `source2`, `wb_valid`, `wb_rd`, `wb_data` and `err` are 0. `in_ready` is 1 one cycle after reset is released and 0 while `rst_n` is low. Reset asserted mid-operation discards any in-flight instruction; no writeback occurs.

## Timing
- Accept at edge N. ALU inputs are valid during cycle N+1. The RF is updated at edge N+1. `wb_valid` is high during cycle N+2.
- Throughput is one op per cycle when there is no stall.
- `in_ready` is combinational from `in_rs1`/`in_rs2`/`e_*` only; it never depends on `in_valid`.
- If `dbg_addr` equals the register being written, `dbg_data` shows the old value until the write edge.

## Configuration
- **`ALU_FWD_EN` defined:** on a RAW hazard, the dependent operand is taken from the E result at accept time. `in_ready` stays 1 and back-to-back dependent ops issue with no bubble.
- **`ALU_FWD_EN` undefined:** on a RAW hazard, `in_ready = 0` for one cycle. The op is accepted the following cycle, once the RF has been written, and reads the updated value. Results are identical to the forwarding build; only timing differs.

## Structure
- **Shared package `alu_pkg`:**
  - `alu_op_e` with OP_ADD=3'b000, OP_SUB, OP_AND, OP_OR, OP_LDI=3'b100.
  - `DATA_W`.
  - `REG_IDX_W`.
  - An `is_writing_op()` function.
- **Sub-module `alu_regfile`:** async read ports for rs1, rs2 and dbg; one synchronous write port; async reset.
- `alu_issue` instantiates `alu_regfile` only. The `Alu` itself is instantiated one level up.

## Test plan
- **LDI then ADD:** LDI r1=1, LDI r2=2, ADD r3=r1+r2 (independent, after both written) → during ALU cycle `alith=000`, `source1=1`, `source2=2`. Next cycle: `wb_rd=3`, `wb_data=3`, `dbg_data` at r3 is 3.
- **Dependent SUB:** LDI r0=5, then immediately SUB r1=r0−r0(=r2 preset to 2 by earlier LDI: SUB r1=r0−r2) → `wb_data=3`.
  - With `ALU_FWD_EN`: no `in_ready` drop.
  - Without it: exactly one cycle of `in_ready=0`.
- **AND/OR:** r1=0xC, r2=0x8; AND → 0x8. r1=0x8, r2=0x1; OR → 0x9. Also ADD 0xFFFF+0x0001 → 0x0000.
- **Illegal op:** accept `in_op=3'b110` → `err` goes 1 and stays 1. No `wb_valid` pulse and RF unchanged. Later legal ops still complete.
- **Reset mid-operation:** accept ADD r3, assert `rst_n` low in the ALU cycle → no `wb_valid`. All RF entries read 0 through `dbg_data`. `alith`/`source1`/`source2` are 0.
- **Back-to-back stream:** 8 independent ops with `in_valid` held high → 8 consecutive `wb_valid` pulses, in order, starting 2 cycles after the first accept.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue/writeback slice.
// Build option: define ALU_FWD_EN to forward E-stage results instead of stalling.
package alu_pkg;

    localparam int DATA_W    = 16;
    localparam int NREG      = 4;
    localparam int REG_IDX_W = $clog2(NREG);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_LDI = 3'b100
    } alu_op_e;

    // Encodings above LDI are illegal and never write the register file.
    function automatic logic is_writing_op(input logic [2:0] op);
        return (op <= OP_LDI);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Small register file: three asynchronous read ports, one synchronous write port,
// asynchronous active-low clear of every entry.
module alu_regfile #(
    parameter int  DATA_W = 16,
    parameter int  NREG   = 4,
    localparam int IDX_W  = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [IDX_W-1:0]  i_rs1_addr,
    input  logic [IDX_W-1:0]  i_rs2_addr,
    input  logic [IDX_W-1:0]  i_dbg_addr,
    output logic [DATA_W-1:0] o_rs1_data,
    output logic [DATA_W-1:0] o_rs2_data,
    output logic [DATA_W-1:0] o_dbg_data
);

    logic [DATA_W-1:0] r_rf [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= '0;
            end
        end else if (i_we) begin
            r_rf[i_waddr] <= i_wdata;
        end
    end

    assign o_rs1_data = r_rf[i_rs1_addr];
    assign o_rs2_data = r_rf[i_rs2_addr];
    assign o_dbg_data = r_rf[i_dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// Two-stage issue/writeback controller in front of an external combinational ALU.
// Build option: ALU_FWD_EN selects E-result forwarding; otherwise RAW hazards stall one cycle.
module alu_issue
    import alu_pkg::*;
#(
    parameter int  DATA_W = 16,
    parameter int  NREG   = 4,
    localparam int IDX_W  = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [IDX_W-1:0]  in_rd,
    input  logic [IDX_W-1:0]  in_rs1,
    input  logic [IDX_W-1:0]  in_rs2,
    input  logic [DATA_W-1:0] in_imm,
    output logic [2:0]        alith,
    output logic [DATA_W-1:0] source1,
    output logic [DATA_W-1:0] source2,
    input  logic [DATA_W-1:0] alu_out,
    output logic              wb_valid,
    output logic [IDX_W-1:0]  wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              err,
    input  logic [IDX_W-1:0]  dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic              r_rdy;
    logic              r_e_valid;
    logic [2:0]        r_e_op;
    logic [IDX_W-1:0]  r_e_rd;
    logic [DATA_W-1:0] r_e_opa;
    logic [DATA_W-1:0] r_e_opb;
    logic [DATA_W-1:0] r_e_imm;
    logic              r_wb_valid;
    logic [IDX_W-1:0]  r_wb_rd;
    logic [DATA_W-1:0] r_wb_data;
    logic              r_err;

    logic [DATA_W-1:0] w_rs1_data;
    logic [DATA_W-1:0] w_rs2_data;
    logic [DATA_W-1:0] w_e_result;
    logic [DATA_W-1:0] w_opa;
    logic [DATA_W-1:0] w_opb;
    logic              w_e_writes;
    logic              w_haz1;
    logic              w_haz2;
    logic              w_accept;

    alu_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_we       (w_e_writes),
        .i_waddr    (r_e_rd),
        .i_wdata    (w_e_result),
        .i_rs1_addr (in_rs1),
        .i_rs2_addr (in_rs2),
        .i_dbg_addr (dbg_addr),
        .o_rs1_data (w_rs1_data),
        .o_rs2_data (w_rs2_data),
        .o_dbg_data (dbg_data)
    );

    assign w_e_writes = r_e_valid && is_writing_op(r_e_op);
    assign w_e_result = (r_e_op == OP_LDI) ? r_e_imm : alu_out;
    assign w_haz1     = w_e_writes && (in_rs1 == r_e_rd);
    assign w_haz2     = w_e_writes && (in_rs2 == r_e_rd);

`ifdef ALU_FWD_EN
    assign in_ready = r_rdy;
    assign w_opa    = w_haz1 ? w_e_result : w_rs1_data;
    assign w_opb    = w_haz2 ? w_e_result : w_rs2_data;
`else
    // Hold off one cycle so the dependent op reads the freshly written RF entry.
    assign in_ready = r_rdy && !(w_haz1 || w_haz2);
    assign w_opa    = w_rs1_data;
    assign w_opb    = w_rs2_data;
`endif

    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy      <= 1'b0;
            r_e_valid  <= 1'b0;
            r_e_op     <= '0;
            r_e_rd     <= '0;
            r_e_opa    <= '0;
            r_e_opb    <= '0;
            r_e_imm    <= '0;
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_rdy      <= 1'b1;
            r_e_valid  <= w_accept;
            // Payload fields hold when idle so the ALU inputs keep their last values.
            if (w_accept) begin
                r_e_op  <= in_op;
                r_e_rd  <= in_rd;
                r_e_opa <= w_opa;
                r_e_opb <= w_opb;
                r_e_imm <= in_imm;
                if (!is_writing_op(in_op)) begin
                    r_err <= 1'b1;
                end
            end
            r_wb_valid <= w_e_writes;
            if (w_e_writes) begin
                r_wb_rd   <= r_e_rd;
                r_wb_data <= w_e_result;
            end
        end
    end

    assign alith    = r_e_op;
    assign source1  = r_e_opa;
    assign source2  = r_e_opb;
    assign wb_valid = r_wb_valid;
    assign wb_rd    = r_wb_rd;
    assign wb_data  = r_wb_data;
    assign err      = r_err;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: in-order reference model of the register file,
// expected ALU drives and writebacks queued at accept, checked by a separate monitor.
module tb_alu_issue;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [1:0]  in_rd;
    logic [1:0]  in_rs1;
    logic [1:0]  in_rs2;
    logic [15:0] in_imm;
    logic [2:0]  alith;
    logic [15:0] source1;
    logic [15:0] source2;
    logic [15:0] alu_out;
    logic        wb_valid;
    logic [1:0]  wb_rd;
    logic [15:0] wb_data;
    logic        err;
    logic [1:0]  dbg_addr;
    logic [15:0] dbg_data;

    alu_issue dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_rd    (in_rd),
        .in_rs1   (in_rs1),
        .in_rs2   (in_rs2),
        .in_imm   (in_imm),
        .alith    (alith),
        .source1  (source1),
        .source2  (source2),
        .alu_out  (alu_out),
        .wb_valid (wb_valid),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .err      (err),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // Stand-in for the external combinational ALU.
    always_comb begin
        alu_out = 16'h0000;
        case (alith)
            3'b000:  alu_out = source1 + source2;
            3'b001:  alu_out = source1 - source2;
            3'b010:  alu_out = source1 & source2;
            3'b011:  alu_out = source1 | source2;
            default: alu_out = 16'h0000;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        int          cyc;
    } alu_exp_t;

    typedef struct {
        logic [1:0]  rd;
        logic [15:0] d;
        int          cyc;
    } wb_exp_t;

    alu_exp_t    alu_q[$];
    wb_exp_t     wb_q[$];
    logic [15:0] mrf [4];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          rcnt     = 0;
    int          last_cyc = -10;
    logic [1:0]  last_rd  = 2'd0;
    logic        last_wr  = 1'b0;
    logic        err_set  = 1'b0;
    int          err_cyc  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rcnt <= 0;
        else        rcnt <= rcnt + 1;
    end

    // Reference model: applies each accepted op in program order and queues expectations.
    always @(negedge clk) begin : model_p
        logic        hz;
        logic        exp_rdy;
        logic [15:0] a, b, res;
        alu_exp_t    ae;
        wb_exp_t     we;
        if (rst_n) begin
            hz = (last_cyc == cyc - 1) && last_wr && (in_rs1 == last_rd || in_rs2 == last_rd);
`ifdef ALU_FWD_EN
            exp_rdy = (rcnt >= 1);
`else
            exp_rdy = (rcnt >= 1) && !hz;
`endif
            chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
            if (in_valid && in_ready) begin
                a = mrf[in_rs1];
                b = mrf[in_rs2];
                ae.op = in_op; ae.a = a; ae.b = b; ae.cyc = cyc;
                alu_q.push_back(ae);
                case (in_op)
                    3'd0:    res = a + b;
                    3'd1:    res = a - b;
                    3'd2:    res = a & b;
                    3'd3:    res = a | b;
                    default: res = in_imm;
                endcase
                if (in_op <= 3'd4) begin
                    mrf[in_rd] = res;
                    we.rd = in_rd; we.d = res; we.cyc = cyc;
                    wb_q.push_back(we);
                end else if (!err_set) begin
                    err_set = 1'b1;
                    err_cyc = cyc;
                end
                last_cyc = cyc;
                last_rd  = in_rd;
                last_wr  = (in_op <= 3'd4);
            end
        end else begin
            chk("in_ready_in_reset", {31'd0, in_ready}, 32'd0);
        end
    end

    // Monitor: pops expectations whenever the DUT presents ALU drive or a writeback.
    always @(negedge clk) begin : mon_p
        alu_exp_t ae;
        wb_exp_t  we;
        while (alu_q.size() > 0 && alu_q[0].cyc < cyc) begin
            ae = alu_q.pop_front();
            chk("alu_cycle", cyc, ae.cyc + 1);
            chk("alith", {29'd0, alith}, {29'd0, ae.op});
            chk("source1", {16'd0, source1}, {16'd0, ae.a});
            chk("source2", {16'd0, source2}, {16'd0, ae.b});
        end
        if (wb_valid) begin
            if (wb_q.size() == 0) begin
                chk("wb_unexpected", {31'd0, wb_valid}, 32'd0);
            end else begin
                we = wb_q.pop_front();
                $display("wb  rd=%0d data=%04h (cycle %0d)", wb_rd, wb_data, cyc);
                chk("wb_cycle", cyc, we.cyc + 2);
                chk("wb_rd", {30'd0, wb_rd}, {30'd0, we.rd});
                chk("wb_data", {16'd0, wb_data}, {16'd0, we.d});
            end
        end
        if (rst_n) begin
            chk("err", {31'd0, err}, {31'd0, (err_set && cyc > err_cyc)});
        end
    end

    task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic [15:0] imm, output int stalls);
        in_valid = 1'b1;
        in_op    = op;
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_imm   = imm;
        stalls   = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (in_ready) break;
            stalls++;
        end
        if (!in_ready) chk("issue_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic dbg_chk(input string name, input logic [1:0] idx, input logic [15:0] exp);
        dbg_addr = idx;
        #1;
        chk(name, {16'd0, dbg_data}, {16'd0, exp});
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        alu_q.delete();
        wb_q.delete();
        for (int i = 0; i < 4; i++) mrf[i] = 16'h0000;
        err_set  = 1'b0;
        last_cyc = -10;
        last_wr  = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int st;
        int tot;
        in_valid = 1'b0; in_op = 3'd0; in_rd = 2'd0; in_rs1 = 2'd0; in_rs2 = 2'd0;
        in_imm = 16'h0; dbg_addr = 2'd0;
        apply_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_source1", {16'd0, source1}, 32'd0);
        release_reset();

        // LDI then independent ADD
        issue(3'd4, 2'd1, 2'd0, 2'd0, 16'd1, st);
        issue(3'd4, 2'd2, 2'd0, 2'd0, 16'd2, st);
        idle(2);
        issue(3'd0, 2'd3, 2'd1, 2'd2, 16'd0, st);
        chk("add_alith", {29'd0, alith}, 32'd0);
        chk("add_source1", {16'd0, source1}, 32'd1);
        chk("add_source2", {16'd0, source2}, 32'd2);
        idle(2);
        dbg_chk("add_r3", 2'd3, 16'd3);

        // Dependent SUB right behind LDI r0
        issue(3'd4, 2'd0, 2'd3, 2'd3, 16'd5, st);
        issue(3'd1, 2'd1, 2'd0, 2'd2, 16'd0, st);
`ifdef ALU_FWD_EN
        chk("sub_stalls", st, 0);
`else
        chk("sub_stalls", st, 1);
`endif
        idle(3);
        dbg_chk("sub_r1", 2'd1, 16'd3);

        // AND / OR / ADD wrap
        issue(3'd4, 2'd1, 2'd0, 2'd0, 16'h000C, st);
        issue(3'd4, 2'd2, 2'd0, 2'd0, 16'h0008, st);
        idle(2);
        issue(3'd2, 2'd3, 2'd1, 2'd2, 16'd0, st);
        idle(3);
        dbg_chk("and_r3", 2'd3, 16'h0008);
        issue(3'd4, 2'd1, 2'd0, 2'd0, 16'h0008, st);
        issue(3'd4, 2'd2, 2'd0, 2'd0, 16'h0001, st);
        idle(2);
        issue(3'd3, 2'd3, 2'd1, 2'd2, 16'd0, st);
        idle(3);
        dbg_chk("or_r3", 2'd3, 16'h0009);
        issue(3'd4, 2'd1, 2'd0, 2'd0, 16'hFFFF, st);
        issue(3'd4, 2'd2, 2'd0, 2'd0, 16'h0001, st);
        idle(2);
        issue(3'd0, 2'd0, 2'd1, 2'd2, 16'd0, st);
        idle(3);
        dbg_chk("add_wrap_r0", 2'd0, 16'h0000);

        // Illegal op: sticky err, RF untouched
        issue(3'd6, 2'd2, 2'd1, 2'd1, 16'h1234, st);
        idle(3);
        chk("illegal_err", {31'd0, err}, 32'd1);
        dbg_chk("illegal_r2", 2'd2, 16'h0001);
        issue(3'd4, 2'd3, 2'd0, 2'd0, 16'h0077, st);
        idle(3);
        dbg_chk("after_illegal_r3", 2'd3, 16'h0077);
        chk("err_sticky", {31'd0, err}, 32'd1);

        // Back-to-back independent stream
        tot = 0;
        for (int k = 0; k < 8; k++) begin
            issue(3'd4, 2'(k % 4), 2'((k + 2) % 4), 2'((k + 2) % 4), 16'(16'h0100 + k), st);
            tot += st;
        end
        idle(4);
        chk("stream_stalls", tot, 0);
        chk("stream_drained", wb_q.size(), 0);

        // Reset during the ALU cycle of an ADD
        issue(3'd0, 2'd3, 2'd1, 2'd2, 16'd0, st);
        apply_reset();
        #1;
        chk("midrst_alith", {29'd0, alith}, 32'd0);
        chk("midrst_source1", {16'd0, source1}, 32'd0);
        chk("midrst_source2", {16'd0, source2}, 32'd0);
        repeat (2) @(negedge clk);
        release_reset();
        for (int i = 0; i < 4; i++) dbg_chk("midrst_rf", 2'(i), 16'h0000);

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
            end else begin
                logic [2:0] op;
                op = ($urandom_range(0, 19) == 0) ? 3'(5 + $urandom_range(0, 2))
                                                  : 3'($urandom_range(0, 4));
                issue(op, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                      2'($urandom_range(0, 3)), 16'($urandom), st);
            end
        end
        idle(4);
        for (int i = 0; i < 4; i++) dbg_chk("final_rf", 2'(i), mrf[i]);
        chk("final_wb_pending", wb_q.size(), 0);
        chk("final_alu_pending", alu_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
